// File: rtl/frog_move_sched.sv
`timescale 1ns/1ps
// Frame-rate move sequencer: WASD keys -> multi-frame hops, log drift merge, bounds/kill handling.
// Optional `FROG_KEY_REPEAT_EN: a held key re-triggers a hop on return to IDLE after COOL.
module frog_move_sched #(
   parameter int X_STEP         = 18,
   parameter int Y_STEP         = 18,
   parameter int HOP_FRAMES     = 3,
   parameter int COOL_FRAMES    = 4,
   parameter int RESPAWN_FRAMES = 8,
   parameter int X_MIN          = 0,
   parameter int X_MAX          = 639,
   parameter int Y_MIN          = 50,
   parameter int Y_MAX          = 438,
   parameter int FROG_SIZE      = 9
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [15:0] keycode,
   input  logic [9:0]  FrogX,
   input  logic [9:0]  FrogY,
   input  logic        drift_req,
   input  logic [9:0]  drift_dx,
   input  logic        kill_req,
   output logic [9:0]  MoveX,
   output logic [9:0]  MoveY,
   output logic        Move_valid,
   output logic        Respawn,
   output logic        Busy,
   output logic [1:0]  HopDir
);
   typedef enum logic [1:0] {IDLE, HOP, COOL, RESPAWN} state_t;

   localparam logic [15:0] KEY_W = 16'h001A;
   localparam logic [15:0] KEY_A = 16'h0004;
   localparam logic [15:0] KEY_S = 16'h0016;
   localparam logic [15:0] KEY_D = 16'h0007;

   localparam logic [9:0]         X_SUB    = 10'(X_STEP / HOP_FRAMES);
   localparam logic [9:0]         Y_SUB    = 10'(Y_STEP / HOP_FRAMES);
   localparam logic signed [11:0] XS       = 12'(X_STEP);
   localparam logic signed [11:0] YS       = 12'(Y_STEP);
   localparam logic signed [11:0] FS       = 12'(FROG_SIZE);
   localparam logic signed [11:0] XMN      = 12'(X_MIN);
   localparam logic signed [11:0] XMX      = 12'(X_MAX);
   localparam logic signed [11:0] YMN      = 12'(Y_MIN);
   localparam logic signed [11:0] YMX      = 12'(Y_MAX);
   localparam logic [7:0]         HOP_CNT  = 8'(HOP_FRAMES);
   localparam logic [7:0]         COOL_CNT = 8'(COOL_FRAMES);
   localparam logic [7:0]         RSP_CNT  = 8'(RESPAWN_FRAMES);

   state_t             state, state_n;
   logic [7:0]         cnt, cnt_n;
   logic               key_armed, armed_n;
   logic               key_hit;
   logic [1:0]         key_dir, hop_d, dir_n;
   logic signed [11:0] fx, fy, tgt_x, tgt_y, drift_x;
   logic               in_bounds, hop_on, drift_on, drift_oob, kill, respawn_n;
   logic [9:0]         hop_dx, hop_dy, mx, my;

   // Keycode decode and hop target bounds check (12-bit signed, never wraps)
   always_comb begin
      key_hit = 1'b1;
      key_dir = 2'd0;
      case (keycode)
         KEY_W:   key_dir = 2'd0;
         KEY_A:   key_dir = 2'd1;
         KEY_S:   key_dir = 2'd2;
         KEY_D:   key_dir = 2'd3;
         default: key_hit = 1'b0;
      endcase
      fx    = signed'({2'b00, FrogX});
      fy    = signed'({2'b00, FrogY});
      tgt_x = fx;
      tgt_y = fy;
      case (key_dir)
         2'd0:    tgt_y = fy - YS;
         2'd1:    tgt_x = fx - XS;
         2'd2:    tgt_y = fy + YS;
         default: tgt_x = fx + XS;
      endcase
      in_bounds = (tgt_x - FS >= XMN) && (tgt_x + FS <= XMX) &&
                  (tgt_y - FS >= YMN) && (tgt_y + FS <= YMX);
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      armed_n   = key_armed | (keycode == 16'h0000);
      dir_n     = HopDir;
      hop_on    = 1'b0;
      hop_d     = HopDir;
      respawn_n = 1'b0;
      case (state)
         IDLE: begin
            if (key_hit && key_armed) begin
               armed_n = 1'b0;
               if (in_bounds) begin
                  state_n = HOP;
                  cnt_n   = HOP_CNT;
                  dir_n   = key_dir;
                  hop_on  = 1'b1;
                  hop_d   = key_dir;
               end
            end
         end
         // The accepting edge already emitted the first sub-step
         HOP: begin
            if (cnt > 8'd1) begin
               hop_on = 1'b1;
               cnt_n  = cnt - 8'd1;
            end else begin
               state_n = COOL;
               cnt_n   = COOL_CNT;
            end
         end
         COOL: begin
            if (cnt <= 8'd1) begin
               state_n = IDLE;
               cnt_n   = 8'd0;
`ifdef FROG_KEY_REPEAT_EN
               armed_n = 1'b1;
`endif
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         default: begin
            armed_n = 1'b0;
            if (cnt <= 8'd1) begin
               state_n = IDLE;
               cnt_n   = 8'd0;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
      endcase

      hop_dx = 10'd0;
      hop_dy = 10'd0;
      if (hop_on) begin
         case (hop_d)
            2'd0:    hop_dy = -Y_SUB;
            2'd1:    hop_dx = -X_SUB;
            2'd2:    hop_dy = Y_SUB;
            default: hop_dx = X_SUB;
         endcase
      end

      drift_on  = drift_req && (state != RESPAWN);
      mx        = hop_dx + (drift_on ? drift_dx : 10'd0);
      my        = hop_dy;
      drift_x   = fx + signed'({{2{mx[9]}}, mx});
      drift_oob = drift_on && ((drift_x - FS < XMN) || (drift_x + FS > XMX));
      kill      = (kill_req || drift_oob) && (state != RESPAWN);

      // Kill overrides everything decided above, including a same-frame key
      if (kill) begin
         state_n   = RESPAWN;
         cnt_n     = RSP_CNT;
         armed_n   = 1'b0;
         dir_n     = HopDir;
         mx        = 10'd0;
         my        = 10'd0;
         respawn_n = 1'b1;
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         key_armed  <= 1'b0;
         MoveX      <= 10'd0;
         MoveY      <= 10'd0;
         Move_valid <= 1'b0;
         Respawn    <= 1'b0;
         Busy       <= 1'b0;
         HopDir     <= 2'd0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         key_armed  <= armed_n;
         MoveX      <= mx;
         MoveY      <= my;
         Move_valid <= (mx != 10'd0) || (my != 10'd0);
         Respawn    <= respawn_n;
         Busy       <= (state_n != IDLE);
         HopDir     <= dir_n;
      end
   end
endmodule
